uart_rx: RTL

UART receiver consuming the 16x-oversampling tick from the baud generator (CLOCK/(BAUD_RATE*16)). It deserializes an asynchronous 8N1 line (start bit, DATA_BITS data bits LSB first, one stop bit) into a parallel word. It reports each received word with a one-clock strobe and a framing-error flag. It sits between the board RX pin and the interface logic that consumes received bytes.

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side result bus of the UART receiver: the received word, its
// completion strobe and the framing-error flag.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_rx_done;
  logic                 o_frame_err;

  modport master (
    output o_data,
    output o_rx_done,
    output o_frame_err
  );

  modport slave (
    input o_data,
    input o_rx_done,
    input o_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by a 16x oversampling tick; delivers each word
// with a one-clock strobe and a framing-error flag.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low (and line seen high since last frame)
// START | counting to mid start bit to confirm it is not a glitch
// DATA  | sampling data bits LSB first, one every 16 ticks
// STOP  | waiting for the stop-bit sample, then publishing the word
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_TICKS = 16
) (
  input  logic      i_clock,
  input  logic      i_reset,
  input  logic      i_tick,
  input  logic      i_rx,
  uart_rx_if.master rx_out
);

  localparam int N_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [N_W-1:0] N_LAST    = N_W'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [3:0]           s_cnt, s_cnt_nxt;
  logic [N_W-1:0]       n, n_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 done_q, done_nxt;
  logic                 armed, armed_nxt;
  logic                 rx_meta, rx_s;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state  <= IDLE;
      s_cnt  <= '0;
      n      <= '0;
      sh     <= '0;
      data_q <= '0;
      ferr_q <= 1'b0;
      done_q <= 1'b0;
      armed  <= 1'b1;
    end else begin
      state  <= state_nxt;
      s_cnt  <= s_cnt_nxt;
      n      <= n_nxt;
      sh     <= sh_nxt;
      data_q <= data_nxt;
      ferr_q <= ferr_nxt;
      done_q <= done_nxt;
      armed  <= armed_nxt;
    end
  end

  // A frame that ends with the line still low (break) disarms start detection
  // until the line has been seen high, so a held-low line yields one strobe.
  always_comb begin
    state_nxt = state;
    s_cnt_nxt = s_cnt;
    n_nxt     = n;
    sh_nxt    = sh;
    data_nxt  = data_q;
    ferr_nxt  = ferr_q;
    done_nxt  = 1'b0;
    armed_nxt = armed | rx_s;

    case (state)
      IDLE: begin
        if (!rx_s && armed) begin
          state_nxt = START;
          s_cnt_nxt = '0;
        end
      end

      START: begin
        if (i_tick) begin
          if (s_cnt == 4'd7) begin
            if (!rx_s) begin
              state_nxt = DATA;
              s_cnt_nxt = '0;
              n_nxt     = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            s_cnt_nxt = s_cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (i_tick) begin
          if (s_cnt == 4'd15) begin
            s_cnt_nxt = '0;
            sh_nxt    = {rx_s, sh[DATA_BITS-1:1]};
            if (n == N_LAST) begin
              state_nxt = STOP;
            end else begin
              n_nxt = n + 1'b1;
            end
          end else begin
            s_cnt_nxt = s_cnt + 4'd1;
          end
        end
      end

      STOP: begin
        if (i_tick) begin
          if (s_cnt == STOP_LAST) begin
            state_nxt = IDLE;
            data_nxt  = sh;
            ferr_nxt  = ~rx_s;
            done_nxt  = 1'b1;
            armed_nxt = rx_s;
          end else begin
            s_cnt_nxt = s_cnt + 4'd1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign rx_out.o_data      = data_q;
  assign rx_out.o_frame_err = ferr_q;
  assign rx_out.o_rx_done   = done_q;

endmodule
